// File: rtl/conv2d_line_buffer.sv
// ============================================================================
// Module  : conv2d_line_buffer
// Brief   : 3x3 sliding-window generator for raster-order pixel streams,
//           built from two row memories and a 3x3 column shift register.
//           Define CONV2D_LB_FRAME_DONE_EN to add the frame_done pulse output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_line_buffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  localparam int PIXEL_WIDTH     = 8,
  localparam int CHANNELS        = 3,
  localparam int PACKED_PIXEL_W  = PIXEL_WIDTH * CHANNELS,
  localparam int WINDOW_ELEMS    = 9,
  localparam int WINDOW_PACKED_W = WINDOW_ELEMS * PACKED_PIXEL_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PACKED_PIXEL_W-1:0]  pixel_in,
  input  logic                       pixel_valid,
  output logic                       pixel_ready,
  input  logic                       flush,
  output logic [WINDOW_PACKED_W-1:0] line_buffer_window,
  output logic                       window_valid,
  input  logic                       window_ready
`ifdef CONV2D_LB_FRAME_DONE_EN
  ,
  output logic                       frame_done
`endif
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [COL_W-1:0]           r_col;
  logic [ROW_W-1:0]           r_row;
  logic                       r_window_valid;
  logic [WINDOW_PACKED_W-1:0] r_window;
  logic [WINDOW_PACKED_W-1:0] w_win_packed;
  logic                       w_accept;
  logic                       w_load;
  logic                       w_col_last;
  logic                       w_row_last;

  logic [PACKED_PIXEL_W-1:0]  r_line1 [IMG_WIDTH];  // row r-1
  logic [PACKED_PIXEL_W-1:0]  r_line2 [IMG_WIDTH];  // row r-2
  logic [PACKED_PIXEL_W-1:0]  r_shift      [3][3];
  logic [PACKED_PIXEL_W-1:0]  w_shift_next [3][3];

  assign pixel_ready        = !r_window_valid || window_ready;
  assign w_accept           = pixel_valid && pixel_ready && !flush;
  assign w_col_last         = (r_col == c_col_last);
  assign w_row_last         = (r_row == c_row_last);
  assign w_load             = w_accept && (r_state == S_STREAM) && (r_col >= COL_W'(2));
  assign window_valid       = r_window_valid;
  assign line_buffer_window = r_window;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_FILL;
    end else if (w_accept && w_col_last) begin
      if (r_state == S_FILL && r_row == ROW_W'(1)) begin
        w_state_next = S_STREAM;
      end else if (r_state == S_STREAM && w_row_last) begin
        w_state_next = S_FILL;
      end
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (flush) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Window columns slide left; the incoming column is {row r-2, row r-1, pixel}
  always_comb begin
    for (int wr = 0; wr < 3; wr++) begin
      w_shift_next[wr][0] = r_shift[wr][1];
      w_shift_next[wr][1] = r_shift[wr][2];
    end
    w_shift_next[0][2] = r_line2[r_col];
    w_shift_next[1][2] = r_line1[r_col];
    w_shift_next[2][2] = pixel_in;
  end

  // Storage without reset: stale contents are overwritten before use
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line2[r_col] <= r_line1[r_col];
      r_line1[r_col] <= pixel_in;
      r_shift        <= w_shift_next;
    end
  end

  for (genvar wr = 0; wr < 3; wr++) begin : g_pack_row
    for (genvar wc = 0; wc < 3; wc++) begin : g_pack_col
      assign w_win_packed[(WINDOW_ELEMS-1-(3*wr+wc))*PACKED_PIXEL_W +: PACKED_PIXEL_W] =
        w_shift_next[wr][wc];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window_valid <= 1'b0;
      r_window       <= '0;
    end else begin
      if (flush) begin
        r_window_valid <= 1'b0;
      end else if (w_load) begin
        r_window_valid <= 1'b1;
      end else if (window_ready) begin
        r_window_valid <= 1'b0;
      end
      if (w_load) begin
        r_window <= w_win_packed;
      end
    end
  end

`ifdef CONV2D_LB_FRAME_DONE_EN
  logic r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
    end
  end

  assign frame_done = r_frame_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv2d_line_buffer.sv
// ============================================================================
// Module  : tb_conv2d_line_buffer
// Brief   : Scoreboard bench for conv2d_line_buffer (4x4 image) with a
//           frame-array reference model and a decoupled window monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2d_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 216;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic          flush = 1'b0;
  logic [WW-1:0] line_buffer_window;
  logic          window_valid;
  logic          window_ready = 1'b0;
`ifdef CONV2D_LB_FRAME_DONE_EN
  logic          frame_done;
`endif

  always #5 clk = ~clk;

  conv2d_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .pixel_ready        (pixel_ready),
    .flush              (flush),
    .line_buffer_window (line_buffer_window),
    .window_valid       (window_valid),
    .window_ready       (window_ready)
`ifdef CONV2D_LB_FRAME_DONE_EN
    ,
    .frame_done         (frame_done)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the frame as seen so far, indexed by raster position
  logic [23:0]   fr [H][W];
  int            mrow = 0;
  int            mcol = 0;
  bit            exp_wv = 0;
  bit            exp_fd = 0;
  logic [WW-1:0] sb [$];
  int            pops = 0;
  logic [WW-1:0] first_win = '0;
  bit            hold_prev = 0;
  logic [WW-1:0] prev_win = '0;
  int            rdy_mode = 0;   // 0: low, 1: high, 2: random

  always @(negedge clk) begin
    bit            acc;
    bit            ld;
    logic [WW-1:0] w;
    if (!rst_n) begin
      mrow = 0; mcol = 0; exp_wv = 0; exp_fd = 0;
      sb.delete();
    end else begin
      chk("window_valid", window_valid, exp_wv);
      chk("pixel_ready", pixel_ready, !exp_wv || window_ready);
`ifdef CONV2D_LB_FRAME_DONE_EN
      chk("frame_done", frame_done, exp_fd);
`endif
      acc    = pixel_valid && (!exp_wv || window_ready) && !flush;
      ld     = 0;
      exp_fd = 0;
      if (acc) begin
        fr[mrow][mcol] = pixel_in;
        if (mrow >= 2 && mcol >= 2) begin
          w = '0;
          for (int p = 0; p < 9; p++)
            w[(8-p)*24 +: 24] = fr[mrow-2+p/3][mcol-2+p%3];
          sb.push_back(w);
          ld = 1;
        end
        exp_fd = (mrow == H-1 && mcol == W-1);
        if (mcol == W-1) begin
          mcol = 0;
          mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      if (flush) begin
        if (exp_wv && !window_ready) void'(sb.pop_front());
        mrow = 0; mcol = 0; exp_wv = 0; exp_fd = 0;
      end else begin
        exp_wv = ld ? 1'b1 : (window_ready ? 1'b0 : exp_wv);
      end
    end
  end

  // Monitor: consumes a window whenever the handshake completes
  always @(negedge clk) begin
    logic [WW-1:0] e;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev && window_valid) chk("window_hold", line_buffer_window, prev_win);
      if (window_valid && window_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_window: got %h expected none", line_buffer_window);
        end else begin
          e = sb.pop_front();
          chk("window_data", line_buffer_window, e);
        end
        if (pops == 0) first_win = line_buffer_window;
        pops++;
      end
      hold_prev = window_valid && !window_ready;
      prev_win  = line_buffer_window;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      window_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [23:0] p);
    int t = 0;
    pixel_in = p; pixel_valid = 1'b1;
    @(negedge clk);
    while (!pixel_ready && t < 200) begin @(negedge clk); t++; end
    if (!pixel_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got pixel_ready=0 expected 1");
    end
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  function automatic logic [23:0] kpix(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, b, b};
  endfunction

  task automatic send_range(input int lo, input int hi, input bit rnd, input int gap);
    for (int k = lo; k <= hi; k++) begin
      send(rnd ? 24'($urandom) : kpix(k));
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic drain_and_count(input string name, input int exp);
    rdy_mode = 1;
    pixel_valid = 1'b0;
    idle(6);
    chk(name, pops, exp);
  endtask

  initial begin
    idle(3);
    chk("reset_window", line_buffer_window, '0);
    chk("reset_window_valid", window_valid, 1'b0);
    chk("reset_pixel_ready", pixel_ready, 1'b1);
    rst_n = 1'b1;

    // Plain frame, downstream always ready
    rdy_mode = 1; idle(1); pops = 0;
    send_range(0, 15, 0, 0);
    drain_and_count("count_plain", 4);
    chk("first_top_left", first_win[215:192], 24'h000000);
    chk("first_elem8_byte", first_win[7:0], 8'h0A);

    // Back-pressure right after the first window
    rdy_mode = 0; idle(1); pops = 0;
    send_range(0, 10, 0, 0);
    pixel_in = kpix(11); pixel_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_pixel_ready", pixel_ready, 1'b0);
      chk("hold_window_valid", window_valid, 1'b1);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    send_range(11, 15, 0, 0);
    drain_and_count("count_backpressure", 4);

    // Flush mid-frame, then a fresh frame
    rdy_mode = 2; pops = 0;
    send_range(0, 7, 0, 0);
    flush = 1'b1; pixel_valid = 1'b1; pixel_in = 24'($urandom);
    idle(1);
    flush = 1'b0; pixel_valid = 1'b0;
    send_range(0, 15, 0, 1);
    drain_and_count("count_after_flush", 4);

    // Asynchronous reset while k=12 is presented
    rdy_mode = 1; idle(1);
    send_range(0, 11, 0, 0);
    pixel_in = kpix(12); pixel_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_window_valid", window_valid, 1'b0);
    chk("async_reset_window", line_buffer_window, '0);
    pixel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pops = 0;
    send_range(0, 15, 0, 0);
    drain_and_count("count_after_reset", 4);

    // Random pixels, random gaps and random back-pressure, back-to-back frames
    rdy_mode = 2; pops = 0;
    repeat (3) send_range(0, 15, 1, 2);
    drain_and_count("count_random", 12);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
